layer_header_bank: RTL and testbench

Parametrised, double-buffered layer header register file for the GPU layer pipeline. The controller writes a shadow bank at any time. The pipeline reads a separate active bank, which updates atomically from the shadow bank at frame boundaries. A sequential clear engine zeroes one layer, or all layers, in the shadow bank with a busy/ready handshake, so writes are never half-applied mid-frame.

---
 rtl/layer_header_bank.sv | 186 ++++++++++++++++++
 tb/tb_layer_header_bank.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_header_bank.sv
// Double-buffered layer header register file: controller-owned shadow bank,
// pipeline-owned active bank committed at frame boundaries, plus a clear engine.
module layer_header_bank #(
    parameter int NUM_LAYERS     = 32,
    parameter int REGS_PER_LAYER = 8,
    parameter int DATA_W         = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [$clog2(NUM_LAYERS)-1:0]        ctrl_layer,
    input  logic [$clog2(REGS_PER_LAYER)-1:0]    ctrl_reg,
    input  logic                                 ctrl_wr_en,
    input  logic [DATA_W-1:0]                    ctrl_wr_data,
    input  logic                                 ctrl_rd_en,
    output logic [DATA_W-1:0]                    ctrl_rd_data,
    output logic                                 ctrl_rd_valid,
    output logic                                 ctrl_ready,
    input  logic                                 clr_req,
    input  logic                                 clr_all,
    output logic                                 clr_busy,
    input  logic                                 frame_sync,
    output logic                                 commit_pending,
    input  logic [$clog2(NUM_LAYERS)-1:0]        pipe_layer,
    output logic [REGS_PER_LAYER*DATA_W-1:0]     pipe_info
);

    localparam int LW     = $clog2(NUM_LAYERS);
    localparam int RW     = $clog2(REGS_PER_LAYER);
    localparam int DEPTH  = NUM_LAYERS * REGS_PER_LAYER;
    localparam int AW     = $clog2(DEPTH);
    localparam int INFO_W = REGS_PER_LAYER * DATA_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [DATA_W-1:0] shadow_r [DEPTH];
    logic [DATA_W-1:0] active_r [DEPTH];

    logic [0:0]        state_r;
    logic [AW-1:0]     clrIdx_r;
    logic [AW-1:0]     clrLast_r;
    logic              clrBusy_r;
    logic              commitPending_r;
    logic [DATA_W-1:0] rdData_r;
    logic              rdValid_r;
    logic [INFO_W-1:0] pipeInfo_r;

    logic              ctrlLayerOk_s;
    logic              ctrlRegOk_s;
    logic              ctrlHit_s;
    logic [AW-1:0]     ctrlBase_s;
    logic [AW-1:0]     ctrlIdx_s;
    logic              clrAccept_s;
    logic              clrDone_s;
    logic              wrAccept_s;
    logic              commitNow_s;
    logic              pipeOk_s;
    logic [AW-1:0]     pipeBase_s;
    logic [INFO_W-1:0] pipeNext_s;

    // Address decode and handshake qualifiers shared by all sequential blocks.
    always_comb begin
        ctrlLayerOk_s = ({1'b0, ctrl_layer} < (LW+1)'(NUM_LAYERS));
        ctrlRegOk_s   = ({1'b0, ctrl_reg} < (RW+1)'(REGS_PER_LAYER));
        ctrlHit_s     = ctrlLayerOk_s && ctrlRegOk_s;
        ctrlBase_s    = AW'(ctrl_layer) * AW'(REGS_PER_LAYER);
        ctrlIdx_s     = ctrlBase_s + AW'(ctrl_reg);
        clrAccept_s   = (state_r == IDLE) && clr_req && (clr_all || ctrlLayerOk_s);
        clrDone_s     = (state_r == CLEAR) && (clrIdx_r == clrLast_r);
        wrAccept_s    = ctrl_wr_en && !clrBusy_r && ctrlHit_s;
        // A deferred commit fires on the first idle cycle even if a new clear starts then.
        commitNow_s   = (state_r == IDLE) && (commitPending_r || (frame_sync && !clrAccept_s));
    end

    // Pipeline lookup of the active bank; out-of-range layers read as zero.
    always_comb begin
        pipeOk_s   = ({1'b0, pipe_layer} < (LW+1)'(NUM_LAYERS));
        pipeBase_s = AW'(pipe_layer) * AW'(REGS_PER_LAYER);
        pipeNext_s = '0;
        if (pipeOk_s) begin
            for (int r = 0; r < REGS_PER_LAYER; r++) begin
                pipeNext_s[r*DATA_W +: DATA_W] = active_r[pipeBase_s + AW'(r)];
            end
        end else begin
            pipeNext_s = '0;
        end
    end

    // Clear engine FSM; the sweep runs over the flat layer-major index range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            clrBusy_r <= 1'b0;
            clrIdx_r  <= '0;
            clrLast_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clrAccept_s) begin
                        state_r   <= CLEAR;
                        clrBusy_r <= 1'b1;
                        if (clr_all) begin
                            clrIdx_r  <= AW'(0);
                            clrLast_r <= AW'(DEPTH - 1);
                        end else begin
                            clrIdx_r  <= ctrlBase_s;
                            clrLast_r <= ctrlBase_s + AW'(REGS_PER_LAYER - 1);
                        end
                    end
                end
                CLEAR: begin
                    if (clrDone_s) begin
                        state_r   <= IDLE;
                        clrBusy_r <= 1'b0;
                    end else begin
                        clrIdx_r  <= clrIdx_r + AW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    clrBusy_r <= 1'b0;
                end
            endcase
        end
    end

    // Shadow bank: the clear engine and controller writes never overlap in time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_r[i] <= '0;
            end
        end else if (state_r == CLEAR) begin
            shadow_r[clrIdx_r] <= '0;
        end else if (wrAccept_s) begin
            shadow_r[ctrlIdx_s] <= ctrl_wr_data;
        end
    end

    // Active bank: atomic copy of the pre-edge shadow contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                active_r[i] <= '0;
            end
        end else if (commitNow_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                active_r[i] <= shadow_r[i];
            end
        end
    end

    // Deferred-commit flag; repeated frame_syncs during a clear collapse into one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commitPending_r <= 1'b0;
        end else if (commitNow_s) begin
            commitPending_r <= frame_sync && clrAccept_s;
        end else if (frame_sync && ((state_r == CLEAR) || clrAccept_s)) begin
            commitPending_r <= 1'b1;
        end
    end

    // Registered controller read port and pipeline view.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdData_r   <= '0;
            rdValid_r  <= 1'b0;
            pipeInfo_r <= '0;
        end else begin
            rdValid_r  <= ctrl_rd_en;
            pipeInfo_r <= pipeNext_s;
            if (ctrl_rd_en) begin
                rdData_r <= ctrlHit_s ? shadow_r[ctrlIdx_s] : '0;
            end
        end
    end

    assign ctrl_rd_data   = rdData_r;
    assign ctrl_rd_valid  = rdValid_r;
    assign ctrl_ready     = !clrBusy_r;
    assign clr_busy       = clrBusy_r;
    assign commit_pending = commitPending_r;
    assign pipe_info      = pipeInfo_r;

endmodule

// File: tb/tb_layer_header_bank.sv
// Directed, table-driven bench for layer_header_bank: default configuration
// plus a small 5x4x8 instance for out-of-range and sweep-length corners.
module tb_layer_header_bank;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0]   ctrlLayer;
    logic [2:0]   ctrlReg;
    logic         wrEn;
    logic [15:0]  wrData;
    logic         rdEn;
    logic [15:0]  rdData;
    logic         rdValid;
    logic         ready;
    logic         clrReq;
    logic         clrAll;
    logic         busy;
    logic         frameSync;
    logic         pending;
    logic [4:0]   pipeLayer;
    logic [127:0] pipeInfo;

    logic [2:0]   sLayer;
    logic [1:0]   sReg;
    logic         sWrEn;
    logic [7:0]   sWrData;
    logic         sRdEn;
    logic [7:0]   sRdData;
    logic         sRdValid;
    logic         sReady;
    logic         sClrReq;
    logic         sClrAll;
    logic         sBusy;
    logic         sFrameSync;
    logic         sPending;
    logic [2:0]   sPipeLayer;
    logic [31:0]  sPipeInfo;

    layer_header_bank #(.NUM_LAYERS(32), .REGS_PER_LAYER(8), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .ctrl_layer(ctrlLayer), .ctrl_reg(ctrlReg),
        .ctrl_wr_en(wrEn), .ctrl_wr_data(wrData),
        .ctrl_rd_en(rdEn), .ctrl_rd_data(rdData), .ctrl_rd_valid(rdValid),
        .ctrl_ready(ready), .clr_req(clrReq), .clr_all(clrAll), .clr_busy(busy),
        .frame_sync(frameSync), .commit_pending(pending),
        .pipe_layer(pipeLayer), .pipe_info(pipeInfo)
    );

    layer_header_bank #(.NUM_LAYERS(5), .REGS_PER_LAYER(4), .DATA_W(8)) dutSmall (
        .clk(clk), .reset(reset),
        .ctrl_layer(sLayer), .ctrl_reg(sReg),
        .ctrl_wr_en(sWrEn), .ctrl_wr_data(sWrData),
        .ctrl_rd_en(sRdEn), .ctrl_rd_data(sRdData), .ctrl_rd_valid(sRdValid),
        .ctrl_ready(sReady), .clr_req(sClrReq), .clr_all(sClrAll), .clr_busy(sBusy),
        .frame_sync(sFrameSync), .commit_pending(sPending),
        .pipe_layer(sPipeLayer), .pipe_info(sPipeInfo)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  layer;
        logic [2:0]  rg;
        logic [15:0] data;
        logic        rd;
        logic        expValid;
        logic [15:0] expData;
    } vec_t;

    vec_t vecs [12];
    int   checks   = 0;
    int   failures = 0;
    int   cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        ctrlLayer = 5'd0; ctrlReg = 3'd0; wrEn = 1'b0; wrData = 16'h0000; rdEn = 1'b0;
        clrReq = 1'b0; clrAll = 1'b0; frameSync = 1'b0; pipeLayer = 5'd0;
        sLayer = 3'd0; sReg = 2'd0; sWrEn = 1'b0; sWrData = 8'h00; sRdEn = 1'b0;
        sClrReq = 1'b0; sClrAll = 1'b0; sFrameSync = 1'b0; sPipeLayer = 3'd0;
        reset = 1'b1;

        vecs[0]  = '{1'b1, 5'd3,  3'd5, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 5'd3,  3'd5, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
        vecs[2]  = '{1'b0, 5'd3,  3'd5, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
        vecs[3]  = '{1'b1, 5'd0,  3'd0, 16'h00A5, 1'b1, 1'b1, 16'h0000};
        vecs[4]  = '{1'b0, 5'd0,  3'd0, 16'h0000, 1'b1, 1'b1, 16'h00A5};
        vecs[5]  = '{1'b1, 5'd2,  3'd7, 16'h1234, 1'b0, 1'b0, 16'h00A5};
        vecs[6]  = '{1'b0, 5'd2,  3'd7, 16'h0000, 1'b1, 1'b1, 16'h1234};
        vecs[7]  = '{1'b1, 5'd31, 3'd7, 16'hFFFF, 1'b0, 1'b0, 16'h1234};
        vecs[8]  = '{1'b0, 5'd31, 3'd7, 16'h0000, 1'b1, 1'b1, 16'hFFFF};
        vecs[9]  = '{1'b0, 5'd3,  3'd4, 16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[10] = '{1'b1, 5'd2,  3'd7, 16'hCAFE, 1'b1, 1'b1, 16'h1234};
        vecs[11] = '{1'b0, 5'd2,  3'd7, 16'h0000, 1'b1, 1'b1, 16'hCAFE};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_data", rdData, 0);
        chk("rst_rd_valid", rdValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_pending", pending, 0);
        chk("rst_pipe", pipeInfo, 0);
        reset = 1'b0;
        step();

        // Write/read table, including same-cycle read-before-write.
        for (int i = 0; i < 12; i++) begin
            wrEn = vecs[i].wr; ctrlLayer = vecs[i].layer; ctrlReg = vecs[i].rg;
            wrData = vecs[i].data; rdEn = vecs[i].rd;
            step();
            chk($sformatf("vec%0d_valid", i), rdValid, vecs[i].expValid);
            chk($sformatf("vec%0d_data", i), rdData, vecs[i].expData);
        end
        wrEn = 1'b0; rdEn = 1'b0;

        // Active bank only follows shadow after a commit.
        pipeLayer = 5'd3;
        step();
        chk("pipe_before_commit", pipeInfo, 0);
        frameSync = 1'b1;
        step();
        frameSync = 1'b0;
        chk("pipe_commit_edge", pipeInfo, 0);
        step();
        chk("pipe_after_commit", pipeInfo, 128'hBEEF << 80);
        pipeLayer = 5'd2;
        step();
        chk("pipe_layer2", pipeInfo, 128'hCAFE << 112);
        pipeLayer = 5'd31;
        step();
        chk("pipe_layer31", pipeInfo, 128'hFFFF << 112);

        // Write coincident with frame_sync misses that commit.
        ctrlLayer = 5'd1; ctrlReg = 3'd2; wrData = 16'h5A5A; wrEn = 1'b1;
        frameSync = 1'b1; pipeLayer = 5'd1;
        step();
        wrEn = 1'b0; frameSync = 1'b0;
        step();
        chk("collide_first_commit", pipeInfo, 0);
        frameSync = 1'b1;
        step();
        frameSync = 1'b0;
        step();
        chk("collide_second_commit", pipeInfo, 128'h5A5A << 32);

        // Single-layer clear of layer 7.
        for (int i = 0; i < 8; i++) begin
            ctrlLayer = 5'd7; ctrlReg = 3'(i); wrData = 16'(i + 1) * 16'h1111; wrEn = 1'b1;
            step();
        end
        ctrlLayer = 5'd6; ctrlReg = 3'd0; wrData = 16'h6666;
        step();
        wrEn = 1'b0;
        ctrlLayer = 5'd7; ctrlReg = 3'd7; rdEn = 1'b1;
        step();
        rdEn = 1'b0;
        chk("fill_l7_r7", rdData, 16'h8888);
        clrReq = 1'b1; clrAll = 1'b0; ctrlLayer = 5'd7;
        step();
        clrReq = 1'b0;
        cnt = 0;
        for (int t = 0; t < 50 && busy; t++) begin
            cnt++;
            if (cnt == 4) begin
                chk("ready_low_busy", ready, 0);
                wrEn = 1'b1; ctrlLayer = 5'd7; ctrlReg = 3'd0; wrData = 16'hDEAD;
            end else begin
                wrEn = 1'b0;
            end
            step();
        end
        wrEn = 1'b0;
        chk("clr_single_cycles", cnt, 8);
        for (int i = 0; i < 8; i++) begin
            ctrlLayer = 5'd7; ctrlReg = 3'(i); rdEn = 1'b1;
            step();
            chk($sformatf("clr_l7_r%0d", i), rdData, 0);
        end
        ctrlLayer = 5'd6; ctrlReg = 3'd0;
        step();
        rdEn = 1'b0;
        chk("clr_l6_kept", rdData, 16'h6666);

        // clr_all with two frame_syncs deferred into a single commit.
        pipeLayer = 5'd3;
        clrReq = 1'b1; clrAll = 1'b1;
        step();
        clrReq = 1'b0; clrAll = 1'b0;
        cnt = 0;
        for (int t = 0; t < 400 && busy; t++) begin
            cnt++;
            frameSync = (cnt == 10 || cnt == 100);
            if (cnt == 12) chk("pending_set", pending, 1);
            if (cnt == 101) chk("active_held", pipeInfo, 128'hBEEF << 80);
            step();
        end
        frameSync = 1'b0;
        chk("clr_all_cycles", cnt, 256);
        chk("pending_first_idle", pending, 1);
        step();
        chk("pending_cleared", pending, 0);
        step();
        chk("deferred_commit_l3", pipeInfo, 0);
        for (int i = 0; i < 32; i++) begin
            pipeLayer = 5'(i);
            step();
            chk($sformatf("post_clear_l%0d", i), pipeInfo, 0);
        end
        chk("pending_stays_low", pending, 0);

        // Async reset in the middle of a clear with a deferred commit.
        ctrlLayer = 5'd4; ctrlReg = 3'd0; wrData = 16'h4444; wrEn = 1'b1;
        step();
        wrEn = 1'b0; frameSync = 1'b1; pipeLayer = 5'd4;
        step();
        frameSync = 1'b0; rdEn = 1'b1;
        step();
        rdEn = 1'b0;
        chk("pre_rst_rd", rdData, 16'h4444);
        chk("pre_rst_pipe", pipeInfo, 128'h4444);
        clrReq = 1'b1; clrAll = 1'b0; ctrlLayer = 5'd4;
        step();
        clrReq = 1'b0; frameSync = 1'b1;
        step();
        frameSync = 1'b0;
        chk("mid_clr_pending", pending, 1);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("arst_rd_data", rdData, 0);
        chk("arst_pipe", pipeInfo, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", ready, 1);
        chk("arst_pending", pending, 0);
        #2 reset = 1'b0;
        step();
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_pending", pending, 0);
        chk("post_rst_pipe", pipeInfo, 0);
        ctrlLayer = 5'd4; ctrlReg = 3'd0; rdEn = 1'b1;
        step();
        rdEn = 1'b0;
        chk("post_rst_shadow", rdData, 0);

        // Small configuration: out-of-range layer and sweep length.
        sLayer = 3'd6; sReg = 2'd1; sWrData = 8'hAB; sWrEn = 1'b1;
        step();
        sWrEn = 1'b0; sRdEn = 1'b1;
        step();
        chk("s_oob_valid", sRdValid, 1);
        chk("s_oob_rd", sRdData, 0);
        sLayer = 3'd4; sReg = 2'd3; sWrData = 8'h5C; sWrEn = 1'b1; sRdEn = 1'b0;
        step();
        sWrEn = 1'b0; sRdEn = 1'b1;
        step();
        chk("s_last_rd", sRdData, 8'h5C);
        sLayer = 3'd6;
        step();
        sRdEn = 1'b0;
        chk("s_oob_rd2", sRdData, 0);
        sFrameSync = 1'b1; sPipeLayer = 3'd4;
        step();
        sFrameSync = 1'b0;
        step();
        chk("s_pipe_l4", sPipeInfo, 32'h5C00_0000);
        sPipeLayer = 3'd6;
        step();
        chk("s_pipe_oob", sPipeInfo, 0);
        sClrReq = 1'b1; sClrAll = 1'b0; sLayer = 3'd6;
        step();
        sClrReq = 1'b0;
        chk("s_clr_oob_ignored", sBusy, 0);
        sClrReq = 1'b1; sClrAll = 1'b1;
        step();
        sClrReq = 1'b0; sClrAll = 1'b0;
        cnt = 0;
        for (int t = 0; t < 100 && sBusy; t++) begin
            cnt++;
            step();
        end
        chk("s_clr_all_cycles", cnt, 20);
        sLayer = 3'd4; sReg = 2'd3; sRdEn = 1'b1;
        step();
        sRdEn = 1'b0;
        chk("s_after_clr", sRdData, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
